// File: rtl/iram_loader_if.sv
// iram_loader_if: host serial line in, instruction-RAM write port and load status out.
interface iram_loader_if;
  logic        uart_rx;
  logic        load_active;
  logic        iram_we;
  logic [7:0]  iram_addr;
  logic [23:0] iram_data;
  logic        load_done;
  logic        load_err;
  modport master (input uart_rx, output load_active, iram_we, iram_addr, iram_data, load_done, load_err);
  modport slave (output uart_rx, input load_active, iram_we, iram_addr, iram_data, load_done, load_err);
endinterface

// File: rtl/iram_loader.sv
// iram_loader: UART 8N1 program loader filling the 24-bit instruction RAM; define LOADER_CHECKSUM_EN
// to require a trailing mod-256 checksum byte after the payload.
module iram_loader #(
  parameter int CLKS_PER_BIT = 868
) (
  input logic clk,
  input logic rst,
  iram_loader_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {L_IDLE, L_PAYLOAD, L_WRITE, L_CHECK, L_DONE} ld_t;
`else
  typedef enum logic [2:0] {L_IDLE, L_PAYLOAD, L_WRITE, L_DONE} ld_t;
`endif

  rx_t rx_state, rx_next;
  ld_t ld_state, ld_next;
  logic [1:0] sync;
  logic rx, rx_prev;
  logic [CW-1:0] tick;
  logic [2:0] bit_idx;
  logic [7:0] rx_byte;
  logic byte_valid, frame_err;
  logic at_half, at_full;
  logic [8:0] wcnt, total;
  logic [1:0] phase;
  logic [15:0] sr;
  logic [23:0] word;
  logic err, last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign rx = sync[1];
  assign at_half = tick == HALF;
  assign at_full = tick == FULL;
  assign last = wcnt + 9'd1 == total;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_state <= RX_IDLE;
      ld_state <= L_IDLE;
    end else begin
      sync <= {sync[0], bus.uart_rx};
      rx_prev <= rx;
      rx_state <= rx_next;
      ld_state <= ld_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  rx_next = (rx_prev && !rx) ? RX_START : RX_IDLE;
      RX_START: rx_next = at_half ? (rx ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  rx_next = (at_full && bit_idx == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP:  rx_next = at_full ? RX_IDLE : RX_STOP;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // tick restarts on every state change so data bits are sampled mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      tick <= (rx_state == RX_IDLE || rx_next != rx_state || at_full) ? '0 : tick + CW'(1);
      if (rx_state == RX_DATA && at_full) begin
        rx_byte <= {rx, rx_byte[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && at_full) begin
        byte_valid <= rx;
        frame_err <= !rx;
      end
    end
  end

  always_comb begin
    ld_next = ld_state;
    unique case (ld_state)
      L_IDLE:    ld_next = byte_valid ? L_PAYLOAD : L_IDLE;
      L_PAYLOAD: ld_next = frame_err ? L_IDLE : (byte_valid && phase == 2'd2) ? L_WRITE : L_PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
      L_WRITE:   ld_next = last ? L_CHECK : L_PAYLOAD;
      L_CHECK:   ld_next = frame_err ? L_IDLE : byte_valid ? (rx_byte == sum ? L_DONE : L_IDLE) : L_CHECK;
`else
      L_WRITE:   ld_next = last ? L_DONE : L_PAYLOAD;
`endif
      L_DONE:    ld_next = L_IDLE;
      default:   ld_next = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      total <= '0;
      phase <= '0;
      sr <= '0;
      word <= '0;
      err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      if (ld_state == L_IDLE && byte_valid) begin
        total <= {rx_byte == 8'd0, rx_byte};
        wcnt <= '0;
        phase <= '0;
        err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum <= '0;
`endif
      end
      if (ld_state == L_PAYLOAD && byte_valid) begin
        sr <= {sr[7:0], rx_byte};
        phase <= phase == 2'd2 ? 2'd0 : phase + 2'd1;
        if (phase == 2'd2) word <= {sr, rx_byte};
`ifdef LOADER_CHECKSUM_EN
        sum <= sum + rx_byte;
`endif
      end
      if (ld_state == L_WRITE) wcnt <= wcnt + 9'd1;
      if (ld_state == L_PAYLOAD && frame_err) err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (ld_state == L_CHECK && (frame_err || (byte_valid && rx_byte != sum))) err <= 1'b1;
`endif
    end
  end

  always_comb begin
    bus.load_active = ld_state != L_IDLE && ld_state != L_DONE;
    bus.iram_we = ld_state == L_WRITE;
    bus.load_done = ld_state == L_DONE;
    bus.iram_addr = wcnt[7:0];
    bus.iram_data = word;
    bus.load_err = err;
  end
endmodule

// File: doc/iram_loader.md
# iram_loader

Serial program loader that fills the 24-bit instruction RAM from a host over UART (8N1). It sits directly upstream of the instruction RAM and drives its write port, data input and external address. It also drives the load flag that switches the iRAM address mux away from the program counter. On completion it pulses a done strobe, which the top level ORs into the CPU reset so execution restarts at PC 0.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); minimum 4.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- uart_rx  input  1  asynchronous serial input; idles high
- load_active  output  1  drives instruction_load_flag; 1 from header accept until done/abort
- iram_we  output  1  iRAM write enable, single-cycle pulse per instruction
- iram_addr  output  8  drives extern_iRAM_addr
- iram_data  output  24  drives iRAM data_in
- load_done  output  1  one-cycle pulse after a successful load
- load_err  output  1  sticky error flag; cleared by rst or next accepted header

## Operation
- RX front end:
  - uart_rx passes through a 2-FF synchronizer, reset to 1.
  - Start is detected on a synchronized 1→0 transition in RX_IDLE.
  - The line is re-sampled at CLKS_PER_BIT/2. If it is high, the start is treated as a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first at CLKS_PER_BIT intervals, then the stop bit.
  - Stop bit = 1 produces a 1-cycle byte_valid with the byte. Stop bit = 0 is a framing error.
- Loader FSM states:
  - L_IDLE: the next valid byte is header N. N=0 means 256 instructions. On header: load_active←1, word counter←0, byte phase←0, load_err←0, checksum←0. Go to L_PAYLOAD.
  - L_PAYLOAD: bytes are assembled MSB first into a 24-bit shift register: byte0→[23:16], byte1→[15:8], byte2→[7:0]. After byte2, issue the write (see Timing) and increment the word counter, 8-bit and wrapping.
    - After N writes, go to L_CHECK if enabled, else L_DONE.
  - L_CHECK: see Configuration.
  - L_DONE: load_done=1 for one cycle, load_active←0, then L_IDLE.
- Framing error in L_PAYLOAD or L_CHECK: load_err←1, load_active←0, return to L_IDLE, no done pulse. Words already written stay in iRAM.
- Framing error in L_IDLE: byte discarded, load_err unchanged.
- iram_addr equals the word counter throughout. iram_data holds the last assembled word.

## Timing
- Reset values: load_active=0, iram_we=0, iram_addr=0, iram_data=0, load_done=0, load_err=0. FSM in L_IDLE, RX in RX_IDLE.
- byte_valid asserts the cycle after the stop-bit sample. The FSM consumes it in that same cycle.
- Write: the cycle after byte2's byte_valid, iram_we=1 for exactly 1 cycle with iram_addr/iram_data stable. The counter increments the following cycle.
- Last write (no checksum): load_done pulses 1 cycle after the last iram_we. load_active falls in the same cycle as load_done.
- load_active rises the cycle after the header's byte_valid.
- rst mid-load: everything returns to reset values next edge. A partially received frame is discarded, with no further writes.
- Host may send the next header immediately after the stop bit. The receiver re-arms in RX_IDLE the cycle after byte_valid.
- N=256: the counter wraps 255→0 on the final increment. The done condition uses a 9-bit count, so exactly 256 writes occur.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the N·3 payload bytes, one more byte is expected. It must equal the 8-bit mod-256 sum of all payload bytes, header excluded.
  - Match: L_DONE, load_done pulses the cycle after the checksum's byte_valid.
  - Mismatch: load_err←1, load_active←0, no done pulse. Written words remain.
- Undefined: no checksum byte, no accumulator logic; L_CHECK is absent and the FSM goes L_PAYLOAD→L_DONE.

## Test plan
Bench uses CLKS_PER_BIT=16.
- Reset, line idle 100 cycles → all outputs 0, no iram_we.
- Send 0x02, 0x12,0x34,0x56, 0xAB,0xCD,0xEF → iram_we pulses twice: addr 0 data 0x123456, addr 1 data 0xABCDEF. load_done pulses once 1 cycle after the 2nd write. load_active high from header+1 until done.
- 4-cycle low glitch on uart_rx in idle → no byte accepted, state unchanged.
- Header 0x01, byte 0x11 with stop bit forced 0 → load_err=1, load_active=0, no iram_we, no load_done. Then header 0x01 + 3 good bytes → load_err clears, 1 write, done pulse.
- Header 0x00 + 768 bytes (word i = {i,i,i}) → 256 writes at addrs 0..255, iram_addr back to 0 after the last, one done pulse.
- LOADER_CHECKSUM_EN: 0x01,0x01,0x02,0x03,0x06 → 1 write of 0x010203 plus done. Same with checksum 0x07 → write occurs, load_err=1, no done.
- rst asserted after 2nd payload byte → outputs at reset values next cycle, no write.
